// File: rtl/life_step_sequencer.sv
// life_step_sequencer
// Computes one Game-of-Life (B3/S23) generation. Rows stream from the current-generation
// BRAM through a sliding window. Each next-generation row goes to the other BRAM of the
// ping-pong pair. The `bank` output tells the top level which BRAM is the source.
module life_step_sequencer #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int WRAP       = 0,
    parameter int GEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  bank,
    output logic [GEN_WIDTH-1:0]  generation,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [COLS-1:0]       rd_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic [COLS-1:0]       wr_data
);

    // Cycle index inside RUN: read slots 0..ROWS+1, write drain ends at ROWS+3.
    localparam int CW = $clog2(ROWS + 4);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);
    localparam logic [CW-1:0] CYC_TWO   = CW'(2);
    localparam logic [CW-1:0] CYC_THREE = CW'(3);
    localparam logic [CW-1:0] CYC_ROWS  = CW'(ROWS);
    localparam logic [CW-1:0] SLOT_END  = CW'(ROWS + 1);
    localparam logic [CW-1:0] ARR_END   = CW'(ROWS + 2);
    localparam logic [CW-1:0] LAST_CYC  = CW'(ROWS + 3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q;
    logic [COLS-1:0]       mid_q, bot_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_en_q;
    logic [COLS-1:0]       wr_data_q;
    logic [GEN_WIDTH-1:0]  gen_q;
    logic                  bank_q;

    logic                  busy_s, done_s, rd_en_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  run_s, enter_run_s, arrive_s, real_arr_s, write_s, finish_s;
    logic [COLS-1:0]       inc_row_s, next_row_s;
    logic [COLS-1:0]       up_w_s, up_e_s, ctr_w_s, ctr_e_s, dn_w_s, dn_e_s;

    // Neighbour to the west of each column: w[c] = row[c-1]. Column 0 wraps or reads dead.
    function automatic logic [COLS-1:0] west_of(input logic [COLS-1:0] row);
        logic edge_bit;
        edge_bit = (WRAP != 0) ? row[COLS-1] : 1'b0;
        return {row[COLS-2:0], edge_bit};
    endfunction

    // Neighbour to the east of each column: e[c] = row[c+1]. Column COLS-1 wraps or reads dead.
    function automatic logic [COLS-1:0] east_of(input logic [COLS-1:0] row);
        logic edge_bit;
        edge_bit = (WRAP != 0) ? row[0] : 1'b0;
        return {edge_bit, row[COLS-1:1]};
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A start is accepted in DONE as well, so steps can run back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cyc_q == LAST_CYC) state_d = ST_DONE;
                else                   state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: status flags and the read port, decoded from state and the cycle index.
    always_comb begin
        busy_s    = 1'b0;
        done_s    = 1'b0;
        rd_en_s   = 1'b0;
        rd_addr_s = '0;
        case (state_q)
            ST_RUN: begin
                busy_s = 1'b1;
                if (cyc_q <= SLOT_END) begin
                    // Slots 0 and ROWS+1 are the halo rows; off-torus they are injected zeros.
                    rd_en_s = (WRAP != 0) || ((cyc_q >= CYC_ONE) && (cyc_q <= CYC_ROWS));
                    if (cyc_q == '0) begin
                        rd_addr_s = ADDR_WIDTH'(ROWS - 1);
                    end else if (cyc_q == SLOT_END) begin
                        rd_addr_s = '0;
                    end else begin
                        rd_addr_s = ADDR_WIDTH'(cyc_q - CYC_ONE);
                    end
                end else begin
                    rd_en_s   = 1'b0;
                    rd_addr_s = '0;
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath decode. The row from slot s arrives in cycle s+1.
    // A row is emitted once its lower neighbour (the incoming row) is available.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        enter_run_s = (state_q != ST_RUN) && (state_d == ST_RUN);
        finish_s    = run_s && (cyc_q == LAST_CYC);
        arrive_s    = run_s && (cyc_q >= CYC_ONE) && (cyc_q <= ARR_END);
        write_s     = run_s && (cyc_q >= CYC_THREE) && (cyc_q <= ARR_END);
        real_arr_s  = (WRAP != 0) || ((cyc_q >= CYC_TWO) && (cyc_q <= SLOT_END));
        if (real_arr_s) begin
            inc_row_s = rd_data;
        end else begin
            inc_row_s = '0;
        end
    end

    // The rows above, at and below the output row are mid_q, bot_q and the incoming row.
    assign up_w_s  = west_of(mid_q);
    assign up_e_s  = east_of(mid_q);
    assign ctr_w_s = west_of(bot_q);
    assign ctr_e_s = east_of(bot_q);
    assign dn_w_s  = west_of(inc_row_s);
    assign dn_e_s  = east_of(inc_row_s);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [3:0] n_s;
        assign n_s = {3'b000, up_w_s[c]}  + {3'b000, mid_q[c]}     + {3'b000, up_e_s[c]}
                   + {3'b000, ctr_w_s[c]} + {3'b000, ctr_e_s[c]}
                   + {3'b000, dn_w_s[c]}  + {3'b000, inc_row_s[c]} + {3'b000, dn_e_s[c]};
        assign next_row_s[c] = (n_s == 4'd3) | (bot_q[c] & (n_s == 4'd2));
    end

    // Cycle index and row window. The window is cleared on entering RUN so halo rows start dead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
        end else if (enter_run_s) begin
            cyc_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
        end else if (run_s) begin
            cyc_q <= cyc_q + CYC_ONE;
            if (arrive_s) begin
                mid_q <= bot_q;
                bot_q <= inc_row_s;
            end else begin
                mid_q <= mid_q;
                bot_q <= bot_q;
            end
        end else begin
            cyc_q <= cyc_q;
        end
    end

    // Registered write port toward the destination BRAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= write_s;
            if (write_s) begin
                wr_addr_q <= ADDR_WIDTH'(cyc_q - CYC_THREE);
                wr_data_q <= next_row_s;
            end else begin
                wr_addr_q <= wr_addr_q;
                wr_data_q <= wr_data_q;
            end
        end
    end

    // Generation count and bank swap take effect only when a step completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_q  <= '0;
            bank_q <= 1'b0;
        end else if (finish_s) begin
            gen_q  <= gen_q + GEN_WIDTH'(1);
            bank_q <= ~bank_q;
        end else begin
            gen_q  <= gen_q;
            bank_q <= bank_q;
        end
    end

    assign busy       = busy_s;
    assign done       = done_s;
    assign rd_en      = rd_en_s;
    assign rd_addr    = rd_addr_s;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign generation = gen_q;
    assign bank       = bank_q;

endmodule
